// File: rtl/rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rv_muldiv_unit
//  Purpose  : Iterative RV32M/RV64M multiply/divide unit for the execute
//             stage. Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a
//             valid/ready handshake so the core only stalls while an M-op is
//             in flight.
//             - Multiply : radix-2 shift-add on operand magnitudes.
//             - Divide   : restoring divider on operand magnitudes.
//             - FIX      : sign correction and result selection.
//             - Divide-by-zero and signed overflow skip the iteration.
//  Config   : RV_MULDIV_FAST_MUL_EN - when defined, MUL* ops use one
//             registered (XLEN+1)x(XLEN+1) signed multiply instead of the
//             iterative multiplier. The divide path is unchanged.
//  Params   : XLEN  - operand/result width (32 or 64)
//             CNT_W - iteration counter width, 2**CNT_W > XLEN
//  Ports    : clk, rst_n (sync, active-low), flush (abort in-flight op)
//             in_valid/in_ready, funct3, src1, src2   - request side
//             out_valid/out_ready, result             - response side
//             busy                                    - unit not idle
//  Revision : 1.0 - initial release
// ============================================================================
module rv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [2*XLEN-1:0]   r_acc;      // product, or {remainder, quotient}
    logic [XLEN-1:0]     r_opb;      // |multiplicand| or |divisor|
    logic [XLEN-1:0]     r_src1;     // raw rs1, needed by the special cases
    logic                r_a_neg;
    logic                r_b_neg;
    logic                r_div_zero;
    logic                r_div_ovf;
    logic [XLEN-1:0]     r_result;

    // ------------------------------------------------------------------
    // Operand decode at accept time
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_s1;
    logic            w_s2;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;

    assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

    // Divides are signed for DIV/REM (funct3[0]==0). Multiplies: MUL/MULH
    // sign both operands, MULHSU only rs1, MULHU neither.
    assign w_s1    = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
    assign w_s2    = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_a_neg = w_s1 & src1[XLEN-1];
    assign w_b_neg = w_s2 & src2[XLEN-1];
    assign w_a_abs = w_a_neg ? -src1 : src1;
    assign w_b_abs = w_b_neg ? -src2 : src2;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_step;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_div_step;

    // Shift-add: the multiplier sits in the low half and is consumed LSB
    // first while the partial product grows in from the top.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                      + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring step: shift {rem, dividend} left by one, try subtracting the
    // divisor from the upper part (XLEN+1 bits so the shifted-out bit is
    // kept), keep the difference if it did not borrow.
    assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opb};
    assign w_div_step  = w_div_trial[XLEN]
                       ? {r_acc[2*XLEN-2:0], 1'b0}
                       : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

`ifdef RV_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fast_a;
    logic signed [XLEN:0]     w_fast_b;
    logic signed [2*XLEN+1:0] w_fast_prod;
    logic                     w_op_s1;
    logic                     w_op_s2;

    assign w_op_s1     = ~(r_op[1] & r_op[0]);
    assign w_op_s2     = ~r_op[1];
    assign w_fast_a    = $signed({w_op_s1 & r_src1[XLEN-1], r_src1});
    assign w_fast_b    = $signed({w_op_s2 & r_opb[XLEN-1], r_opb});
    assign w_fast_prod = w_fast_a * w_fast_b;
`endif

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic              w_mul_neg;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;
    logic [XLEN-1:0]   w_special;

`ifdef RV_MULDIV_FAST_MUL_EN
    // The signed multiplier already produced the correctly signed product.
    assign w_mul_neg = 1'b0;
`else
    assign w_mul_neg = r_a_neg ^ r_b_neg;
`endif

    assign w_prod_fix = w_mul_neg ? -r_acc : r_acc;
    assign w_quot_fix = (r_a_neg ^ r_b_neg) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_a_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            3'b000:                w_fix_result = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:        w_fix_result = w_quot_fix;
            default:               w_fix_result = w_rem_fix;
        endcase
    end

    // Divide by zero wins over overflow (src2=0 cannot also be -1).
    assign w_special = r_div_zero ? (r_op[1] ? r_src1 : {XLEN{1'b1}})
                                  : (r_op[1] ? {XLEN{1'b0}} : r_src1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = funct3[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
`ifdef RV_MULDIV_FAST_MUL_EN
                w_state_nxt = S_FIX;
`else
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
`endif
            end
            S_DIV: begin
                if (r_div_zero || r_div_ovf) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A redirect aborts whatever is in flight, including a pending result.
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_src1     <= '0;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
        end else if (w_accept) begin
            r_op       <= funct3;
            r_cnt      <= CNT_W'(XLEN-1);
            r_src1     <= src1;
            r_a_neg    <= w_a_neg;
            r_b_neg    <= w_b_neg;
            r_div_zero <= (src2 == '0);
            r_div_ovf  <= funct3[2] && !funct3[0]
                          && (src1 == MOST_NEG) && (src2 == {XLEN{1'b1}});
            r_acc      <= {{XLEN{1'b0}}, w_a_abs};
`ifdef RV_MULDIV_FAST_MUL_EN
            r_opb      <= funct3[2] ? w_b_abs : src2;
`else
            r_opb      <= w_b_abs;
`endif
        end else if (!flush) begin
            case (r_state)
                S_MUL: begin
`ifdef RV_MULDIV_FAST_MUL_EN
                    r_acc <= w_fast_prod[2*XLEN-1:0];
`else
                    r_acc <= w_mul_step;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
`endif
                end
                S_DIV: begin
                    if (r_div_zero || r_div_ovf) begin
                        r_result <= w_special;
                    end else begin
                        r_acc <= w_div_step;
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire
